// File: rtl/round_dequant_stream.sv
// round_dequant_stream
//   Streaming dequantizer. It takes OUT_WIDTH-bit quantized samples and emits
//   IN_WIDTH-bit reconstructions (q << DIV_LOG2), passing them through a
//   2-entry FIFO so that either side can stall at full rate. It also counts
//   delivered samples.
//
// Ports
//   clk, reset        clock and synchronous active-high reset
//   din_valid/ready   input handshake; din is the quantized sample
//   dout_valid/ready  output handshake; dout is the reconstructed sample
//   clear             synchronously zeroes sample_cnt (wins over a pop)
//   sample_cnt        number of completed output transfers, wraps

module round_dequant_stream #(
  parameter int DIV_LOG2  = 3,
  parameter int OUT_WIDTH = 32,
  parameter int IN_WIDTH  = OUT_WIDTH + DIV_LOG2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic [OUT_WIDTH-1:0] din,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [IN_WIDTH-1:0]  dout,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] sample_cnt
);

  logic [1:0][IN_WIDTH-1:0] mem;
  logic                     rd_ptr, wr_ptr;
  logic [1:0]               occ;
  logic                     push, pop;
  logic [IN_WIDTH-1:0]      word;

  // Exact inverse of the quantizer's divide, so no rounding is needed here.
  // Because the word is only widened, it can never overflow.
  assign word = IN_WIDTH'({din, {DIV_LOG2{1'b0}}});

  // Both handshake outputs depend only on occupancy. As a result, dout_ready
  // has no combinational path to din_ready.
  assign din_ready  = (occ != 2'd2);
  assign dout_valid = (occ != 2'd0);
  assign dout       = mem[rd_ptr];

  assign push = din_valid & din_ready;
  assign pop  = dout_valid & dout_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      occ        <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      mem        <= '0;
      sample_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= word;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      // A push and a pop together can only happen at occ=1. In that case
      // occupancy holds, the head advances, and the new entry fills the other slot.
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
      if (clear)    sample_cnt <= '0;
      else if (pop) sample_cnt <= sample_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_round_dequant_stream.sv
// tb_round_dequant_stream
//   Randomized scoreboard bench for round_dequant_stream. The stimulus process
//   drives inputs 1 time unit after each rising edge. At each falling edge the
//   monitor compares the DUT against a queue-based reference model and then
//   advances that model.

module tb_round_dequant_stream;
  localparam int DL = 3, OW = 32, IW = OW + DL, CW = 16;

  logic          clk = 1'b0, reset = 1'b1;
  logic          din_valid = 1'b0, dout_ready = 1'b0, clear = 1'b0;
  logic [OW-1:0] din = '0;
  logic          din_ready, dout_valid;
  logic [IW-1:0] dout;
  logic [CW-1:0] sample_cnt;

  round_dequant_stream #(.DIV_LOG2(DL), .OUT_WIDTH(OW), .IN_WIDTH(IW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din_ready(din_ready), .din(din),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout), .clear(clear),
    .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: this queue holds the original samples that are buffered
  // inside the DUT. Its size is the occupancy and its front is the head.
  logic [OW-1:0] qd[$];
  logic [CW-1:0] exp_cnt = '0;
  bit            post_rst = 1'b0;
  int            pops = 0;
  int            m_chk = 0, m_err = 0, s_chk = 0, s_err = 0;

  function automatic bit cmp(string name, logic [63:0] got, logic [63:0] exp);
    if (got !== exp) begin
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic mchk(string name, logic [63:0] got, logic [63:0] exp);
    m_chk++;
    if (!cmp(name, got, exp)) m_err++;
  endtask

  task automatic schk(string name, logic [63:0] got, logic [63:0] exp);
    s_chk++;
    if (!cmp(name, got, exp)) s_err++;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    bit do_pop, do_push;
    logic [63:0] recon;
    mchk("cnt", 64'(sample_cnt), 64'(exp_cnt));
    mchk("din_ready", 64'(din_ready), 64'(qd.size() != 2));
    mchk("dout_valid", 64'(dout_valid), 64'(qd.size() != 0));
    if (qd.size() != 0) mchk("dout_head", 64'(dout), 64'(qd[0]) * (64'd1 << DL));
    if (post_rst) mchk("dout_after_reset", 64'(dout), 64'd0);
    if (reset) begin
      qd.delete();
      exp_cnt  = '0;
      post_rst = 1'b1;
    end else begin
      do_pop  = (qd.size() != 0) && dout_ready;
      do_push = din_valid && (qd.size() != 2);
      if (do_pop) begin
        // Round-half-up quantizer must recover the original sample
        recon = (64'(dout) + (64'd1 << (DL - 1))) >> DL;
        mchk("roundtrip", recon, 64'(qd[0]));
        void'(qd.pop_front());
        pops++;
      end
      if (clear)       exp_cnt = '0;
      else if (do_pop) exp_cnt = exp_cnt + 1'b1;
      if (do_push) begin
        qd.push_back(din);
        post_rst = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    for (int i = 0; i < 10 && qd.size() != 0; i++) step();
    schk("drain_timeout", 64'(qd.size()), 64'd0);
  endtask

  initial begin
    int p0;
    step(); step();
    reset = 1'b0;

    // 1: single sample, 1-cycle latency
    din = 5; din_valid = 1'b1; dout_ready = 1'b1;
    step();
    din_valid = 1'b0;
    schk("t1_dout", 64'(dout), 64'd40);
    schk("t1_valid", 64'(dout_valid), 64'd1);
    step();
    schk("t1_cnt", 64'(sample_cnt), 64'd1);

    // 2: all-ones sample
    din = 32'hFFFF_FFFF; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    schk("t2_dout", 64'(dout), 64'h7_FFFF_FFF8);
    step();

    // 3: fill while stalled, third sample refused, ordered drain
    dout_ready = 1'b0;
    din = 1; din_valid = 1'b1; step();
    din = 2; step();
    schk("t3_full", 64'(din_ready), 64'd0);
    din = 3; step(); step();
    schk("t3_still_full", 64'(din_ready), 64'd0);
    schk("t3_hold", 64'(dout), 64'd8);
    din_valid = 1'b0; dout_ready = 1'b1;
    step();
    schk("t3_second", 64'(dout), 64'd16);
    step();
    schk("t3_ready", 64'(din_ready), 64'd1);
    schk("t3_empty", 64'(dout_valid), 64'd0);

    // 4: full-rate stream of 1000 random samples
    p0 = pops;
    din_valid = 1'b1; dout_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      din = $urandom; step();
    end
    din_valid = 1'b0;
    step();
    schk("t4_throughput", 64'(pops - p0), 64'd1000);

    // random stalls on both sides
    for (int i = 0; i < 600; i++) begin
      din = $urandom; din_valid = 1'($urandom_range(0, 1));
      dout_ready = 1'($urandom_range(0, 1)); step();
    end
    drain();

    // 5: counter wrap and clear priority
    clear = 1'b1; step(); clear = 1'b0;
    schk("t5_cleared", 64'(sample_cnt), 64'd0);
    din_valid = 1'b1; dout_ready = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      din = $urandom; step();
    end
    din_valid = 1'b0; step();
    schk("t5_ffff", 64'(sample_cnt), 64'hFFFF);
    din = 1; din_valid = 1'b1; step();
    din_valid = 1'b0; step();
    schk("t5_wrap", 64'(sample_cnt), 64'd0);
    dout_ready = 1'b0; din = 2; din_valid = 1'b1; step();
    din_valid = 1'b0; dout_ready = 1'b1; clear = 1'b1; step();
    clear = 1'b0;
    schk("t5_clear_pop", 64'(sample_cnt), 64'd0);
    schk("t5_popped", 64'(dout_valid), 64'd0);

    // 6: reset while full
    dout_ready = 1'b0; din_valid = 1'b1;
    din = 4; step();
    din = 5; step();
    schk("t6_full", 64'(din_ready), 64'd0);
    din_valid = 1'b0; reset = 1'b1; step();
    schk("t6_valid", 64'(dout_valid), 64'd0);
    schk("t6_dout", 64'(dout), 64'd0);
    schk("t6_ready", 64'(din_ready), 64'd1);
    schk("t6_cnt", 64'(sample_cnt), 64'd0);
    din = 9; din_valid = 1'b1; step();
    schk("t6_ignored", 64'(dout_valid), 64'd0);
    reset = 1'b0; din = 7; dout_ready = 1'b1; step();
    din_valid = 1'b0;
    schk("t6_first", 64'(dout), 64'd56);
    step();
    drain();

    $display("CHECKS %0d ERRORS %0d", s_chk + m_chk, s_err + m_err);
    $finish;
  end

endmodule
